// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: the pixel word width and type used from the SPI front end
// through the panel pipeline.
package hub75_pkg;

  localparam int WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] pixel_word_t;

endpackage

// File: rtl/spi_slave.sv
// Receive-only SPI slave (mode 0): deserialises MOSI MSB first into words and
// strobes pixel_clock for one spi_clk cycle as each word completes.
module spi_slave #(
  parameter int WORD_WIDTH = hub75_pkg::WORD_WIDTH
) (
  input  logic                  spi_clk,
  input  logic                  reset,
  input  logic                  spi_mosi,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  pixel_clock
);

  localparam int                     COUNT_WIDTH = $clog2(WORD_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_BIT    = COUNT_WIDTH'(WORD_WIDTH - 1);

  // Only WORD_WIDTH-1 bits need storing: the final bit comes straight from MOSI.
  logic [WORD_WIDTH-2:0]  shift;
  logic [COUNT_WIDTH-1:0] bit_count;
  logic                   word_done;
  logic [WORD_WIDTH-1:0]  next_word;

  assign word_done = (bit_count == LAST_BIT);
  assign next_word = {shift, spi_mosi};

  // No chip select exists, so reset is the only thing that re-aligns word framing.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      shift       <= '0;
      bit_count   <= '0;
      data        <= '0;
      pixel_clock <= 1'b0;
    end else begin
      shift       <= next_word[WORD_WIDTH-2:0];
      bit_count   <= word_done ? '0 : bit_count + COUNT_WIDTH'(1);
      pixel_clock <= word_done;
      if (word_done) begin
        data <= next_word;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised scoreboard bench for spi_slave: words are queued as they are shifted in
// and a negedge monitor checks every strobe and the held data against a word-level model.
module tb_spi_slave;
  import hub75_pkg::*;

  logic        spi_clk  = 1'b0;
  logic        reset    = 1'b0;
  logic        spi_mosi = 1'b0;
  logic [15:0] data;
  logic        pixel_clock;

  int total       = 0;
  int bad         = 0;
  int pulse_count = 0;
  int word_count  = 0;

  // Model: the last fully sent word and whether the most recent edge completed one.
  pixel_word_t exp_q[$];
  pixel_word_t exp_data  = '0;
  logic        exp_pulse = 1'b0;

  spi_slave #(.WORD_WIDTH(16)) dut (
    .spi_clk     (spi_clk),
    .reset       (reset),
    .spi_mosi    (spi_mosi),
    .data        (data),
    .pixel_clock (pixel_clock)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Shifts the top nbits of w out MSB first; only a full word becomes an expected output.
  task automatic applyStimulus(input pixel_word_t w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = w[15-i];
      #5;
      spi_clk = 1'b1;
      if (i == 15) begin
        exp_data  = w;
        exp_pulse = 1'b1;
        exp_q.push_back(w);
        word_count++;
      end else begin
        exp_pulse = 1'b0;
      end
      #5;
      spi_clk = 1'b0;
    end
  endtask

  task automatic doReset();
    spi_clk = 1'b0;
    reset   = 1'b1;
    #5;
    checkOutput("reset_data", 32'(data), 32'h0);
    checkOutput("reset_pixel_clock", 32'(pixel_clock), 32'h0);
    spi_mosi = 1'b1;
    #5 spi_clk = 1'b1;
    #5 spi_clk = 1'b0;
    checkOutput("reset_ignores_clk_data", 32'(data), 32'h0);
    checkOutput("reset_ignores_clk_pixel", 32'(pixel_clock), 32'h0);
    exp_data  = '0;
    exp_pulse = 1'b0;
    exp_q.delete();
    #5 reset = 1'b0;
    #5;
  endtask

  always @(negedge spi_clk) begin
    if (!reset) begin
      checkOutput("pixel_clock", 32'(pixel_clock), 32'(exp_pulse));
      checkOutput("data_held", 32'(data), 32'(exp_data));
      if (pixel_clock) begin
        pulse_count++;
        checkOutput("pulse_has_word", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          checkOutput("scoreboard_word", 32'(data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int p0;
    pixel_word_t w;

    doReset();

    applyStimulus(16'h1234, 16);
    #20;
    checkOutput("single_word_data", 32'(data), 32'h1234);
    checkOutput("stopped_clk_pixel_held", 32'(pixel_clock), 32'h1);

    applyStimulus(16'hABCD, 16);
    applyStimulus(16'h0001, 16);
    checkOutput("b2b_second_word", 32'(data), 32'h0001);

    p0 = pulse_count;
    applyStimulus(16'hFFFF, 16);
    applyStimulus(16'h0000, 16);
    checkOutput("extremes_pulses", 32'(pulse_count - p0), 32'd2);
    checkOutput("extremes_last", 32'(data), 32'h0000);

    applyStimulus(16'hFF00, 8);
    doReset();
    applyStimulus(16'h5A5A, 16);
    checkOutput("realign_after_reset", 32'(data), 32'h5A5A);

    p0 = pulse_count;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pixel_word_t'($urandom), 16);
    end
    checkOutput("stream4_pulses", 32'(pulse_count - p0), 32'd4);

    for (int i = 0; i < 150; i++) begin
      w = pixel_word_t'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        applyStimulus(w, $urandom_range(1, 15));
        doReset();
      end else begin
        applyStimulus(w, 16);
        if ($urandom_range(0, 3) == 0) begin
          #($urandom_range(1, 30));
          checkOutput("gap_data", 32'(data), 32'(exp_data));
          checkOutput("gap_pixel", 32'(pixel_clock), 32'(exp_pulse));
        end
      end
    end

    #10;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("pulse_total", 32'(pulse_count), 32'(word_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
